// File: rtl/muldiv_if.sv
// Request/result bundle for the sequential multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hilo_write;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hilo_write, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hilo_write, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Signed MIPS-style multiply (radix-2 Booth) / divide (restoring) unit,
// one iteration per cycle, results published to HI/LO on entry to DONE.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   mcand;      // multiplicand, or divisor magnitude
    logic [2*WIDTH:0]   booth;      // {acc, q, q-1}
    logic [WIDTH-1:0]   rem, quo;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               dz_r, hw_r;

    logic               accept;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH:0]     bsum;
    logic [2*WIDTH:0]   booth_nxt;
    logic [WIDTH:0]     dtmp;
    logic [WIDTH+1:0]   ddiff;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign accept = bus.start && (state == S_IDLE || state == S_DONE);
    assign acc    = booth[2*WIDTH:WIDTH+1];
    assign abs_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Sum kept one bit wider so -(-2^31) does not wrap before the shift.
    always_comb begin
        bsum = {acc[WIDTH-1], acc};
        case (booth[1:0])
            2'b01:   bsum = {acc[WIDTH-1], acc} + {mcand[WIDTH-1], mcand};
            2'b10:   bsum = {acc[WIDTH-1], acc} - {mcand[WIDTH-1], mcand};
            default: bsum = {acc[WIDTH-1], acc};
        endcase
        booth_nxt = {bsum, booth[WIDTH:1]};
    end

    assign dtmp  = {rem, quo[WIDTH-1]};
    assign ddiff = {1'b0, dtmp} - {2'b00, mcand};

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (bus.start) begin
                    if (!bus.op)          state_nxt = S_MULT;
                    else if (bus.b == '0) state_nxt = S_DONE;
                    else                  state_nxt = S_DIV;
                end
            end
            S_MULT:  if (cnt == LAST) state_nxt = S_DONE;
            S_DIV:   if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            mcand <= '0;
            booth <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_r  <= '0;
            lo_r  <= '0;
            dz_r  <= 1'b0;
            hw_r  <= 1'b0;
        end else begin
            dz_r <= 1'b0;
            hw_r <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (!bus.op) begin
                            mcand <= bus.a;
                            booth <= {{WIDTH{1'b0}}, bus.b, 1'b0};
                        end else if (bus.b == '0) begin
                            dz_r <= 1'b1;
                        end else begin
                            mcand <= abs_b;
                            rem   <= '0;
                            quo   <= abs_a;
                            neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_r <= bus.a[WIDTH-1];
                        end
                    end
                end
                S_MULT: begin
                    booth <= booth_nxt;
                    cnt   <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        hi_r <= booth_nxt[2*WIDTH:WIDTH+1];
                        lo_r <= booth_nxt[WIDTH:1];
                        hw_r <= 1'b1;
                    end
                end
                S_DIV: begin
                    cnt <= cnt + 6'd1;
                    if (!ddiff[WIDTH+1]) begin
                        rem <= ddiff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= dtmp[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    // -2^31 / -1 lands here with neg_q=0 and quo=0x80000000.
                    hi_r <= neg_r ? -rem : rem;
                    lo_r <= neg_q ? -quo : quo;
                    hw_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
    assign bus.done       = (state == S_DONE);
    assign bus.div_zero   = dz_r;
    assign bus.hilo_write = hw_r;
    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against a latency/arithmetic model.
module tb_muldiv_seq;
    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!op) return 64'(sx * sy);
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: fixed latency after accept, results from plain signed arithmetic.
    logic        m_busy, m_done, m_dz, m_hw;
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    initial begin
        m_busy = 0; m_done = 0; m_dz = 0; m_hw = 0;
        m_left = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
    end

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_dz <= 0; m_hw <= 0;
            m_left <= 0; m_hi <= 0; m_lo <= 0;
        end else if (m_busy) begin
            m_done <= 0; m_dz <= 0; m_hw <= 0;
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 0; m_done <= 1; m_hw <= 1;
                m_hi <= p_hi; m_lo <= p_lo;
            end
        end else begin
            m_done <= 0; m_dz <= 0; m_hw <= 0;
            if (bus.start) begin
                if (bus.op && bus.b == 32'd0) begin
                    m_done <= 1; m_dz <= 1;
                end else begin
                    {p_hi, p_lo} <= ref_calc(bus.op, bus.a, bus.b);
                    m_busy <= 1;
                    m_left <= bus.op ? 33 : 32;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("busy",       64'(bus.busy),       64'(m_busy));
        chk("done",       64'(bus.done),       64'(m_done));
        chk("div_zero",   64'(bus.div_zero),   64'(m_dz));
        chk("hilo_write", 64'(bus.hilo_write), 64'(m_hw));
        chk("hi",         64'(bus.hi),         64'(m_hi));
        chk("lo",         64'(bus.lo),         64'(m_lo));
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Caller sits at #2 after the accept edge (cycle 1).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 60) begin
            @(posedge clock); #2;
            lat++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && bus.busy; i++) begin
            @(posedge clock); #2;
        end
    endtask

    task automatic run_op(input string name, input logic op, input logic [31:0] x, input logic [31:0] y,
                          input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        wait_idle();
        bus.start = 1; bus.op = op; bus.a = x; bus.b = y;
        @(posedge clock); #2;
        bus.start = 0; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_hi"},  64'(bus.hi), 64'(exp_hi));
        chk({name, "_lo"},  64'(bus.lo), 64'(exp_lo));
        chk({name, "_hw"},  64'(bus.hilo_write), 64'(exp_lat != 1));
        chk({name, "_dz"},  64'(bus.div_zero),   64'(exp_lat == 1));
        @(posedge clock); #2;
    endtask

    initial begin
        int lat;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        reset = 1;
        repeat (3) @(posedge clock);
        #2 reset = 0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        chk("model_mul", ref_calc(1'b0, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_div", ref_calc(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_ovf", ref_calc(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        run_op("mul_7x-3",   1'b0, 32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mul_min",    1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000);
        run_op("div_-7/2",   1'b1, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
        run_op("div_95/10",  1'b1, 32'd95,        32'd10,        34, 32'd5,         32'd9);
        run_op("div_zero",   1'b1, 32'd123,       32'd0,         1,  32'd5,         32'd9);

        // Reset in the middle of a multiply, with a stray start while busy.
        wait_idle();
        bus.start = 1; bus.op = 0; bus.a = 3; bus.b = 4;
        @(posedge clock); #2;
        bus.start = 0;
        for (int c = 1; c < 20; c++) begin
            bus.start = (c == 10); bus.op = 1;
            @(posedge clock); #2;
        end
        bus.start = 0;
        reset = 1;
        @(posedge clock); #2;
        reset = 0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (40) @(posedge clock);
        #2;
        run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 33, 32'd0, 32'd12);

        // Start held high straight through DONE: back-to-back accept.
        wait_idle();
        bus.start = 1; bus.op = 0; bus.a = 2; bus.b = 3;
        @(posedge clock); #2;
        bus.a = 5; bus.b = 6;
        wait_done(lat);
        chk("b2b_lat1", 64'(lat), 64'd33);
        chk("b2b_lo1",  64'(bus.lo), 64'd6);
        @(posedge clock); #2;
        bus.start = 0;
        wait_done(lat);
        chk("b2b_lat2", 64'(lat), 64'd33);
        chk("b2b_res2", {bus.hi, bus.lo}, 64'd30);
        @(posedge clock); #2;

        for (int c = 0; c < 3000; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 1'($urandom_range(0, 1));
            bus.a     = pick();
            bus.b     = pick();
            reset     = ($urandom_range(0, 399) == 0);
            @(posedge clock); #2;
        end
        reset = 0; bus.start = 0;
        repeat (40) @(posedge clock);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- op  in  1  0=MULT, 1=DIV, both signed
- a  in  32  multiplicand / dividend (register A)
- b  in  32  multiplier / divisor (register B)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero pulse
- hilo_write  out  1  one-cycle HI/LO update pulse
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient

Function
REQ-004 The state machine SHALL have five states: IDLE, MULT, DIV, FIX, DONE.
REQ-005 Accept condition: start=1 while in IDLE or DONE.
- a, b and op are captured on that edge.
- Later changes on a, b or op have no effect.
REQ-006 On accept, the next state SHALL be:
- MULT when op=0
- DIV when op=1 and b!=0
- DONE with div_zero=1 when op=1 and b==0
REQ-007 MULT SHALL run radix-2 Booth: 32 iterations, one per cycle, with a 6-bit counter, using a 65-bit {acc, q, q-1} arithmetic-shift register.
REQ-008 DIV SHALL run restoring division on magnitudes: 32 iterations, one per cycle, then one FIX cycle.
REQ-009 FIX SHALL correct signs per MIPS rules:
- quotient truncates toward zero
- remainder takes the sign of the dividend
REQ-010 Boundary case -2^31 / -1 SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-011 Latency, counted from the accept edge as cycle 0:
- MULT: done=1 in cycle 33
- DIV: done=1 in cycle 34
- divide-by-zero: done=1 in cycle 1
REQ-012 DONE SHALL last exactly one cycle.
- With start=0, the next state is IDLE.
- With start=1, DONE SHALL accept a new operation per REQ-005 and REQ-006.
REQ-013 busy SHALL be 1 in MULT, DIV and FIX, and 0 in IDLE and DONE.
REQ-014 hi and lo SHALL change only on the edge entering DONE after a successful operation; hilo_write=1 during that DONE cycle.
REQ-015 On divide-by-zero:
- hi and lo SHALL hold their previous values
- hilo_write=0
- done=1 and div_zero=1 in the same cycle
REQ-016 start=1 while busy=1 SHALL be ignored: no restart, no queuing, no effect on the result.
REQ-017 Internal working registers SHALL NOT be visible on hi or lo until DONE.
REQ-018 done, div_zero and hilo_write SHALL be driven directly from registered state, with no combinational path from start.

Reset
REQ-019 reset=1 at any clock edge SHALL force IDLE and clear all state, including mid-operation; any partial result is discarded.
REQ-020 Reset values SHALL be:
- busy=0, done=0, div_zero=0, hilo_write=0
- hi=0x00000000, lo=0x00000000
- iteration counter 0
REQ-021 reset SHALL take priority over start on the same edge.

Verification
REQ-022 MULT a=7, b=0xFFFFFFFD (-3) -> cycle 33: done=1, hilo_write=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 in cycles 1-32.
REQ-023 MULT a=0x80000000, b=0x80000000 -> cycle 33: hi=0x40000000, lo=0x00000000.
REQ-024 DIV a=0xFFFFFFF9 (-7), b=2 -> cycle 34: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Second case: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 DIV with b=0 after a prior result hi=5, lo=9 -> cycle 1: done=1, div_zero=1, hilo_write=0; hi=5 and lo=9 unchanged; busy never 1.
REQ-026 Start MULT 3*4, pulse start with op=1 in cycle 10, assert reset in cycle 20 -> cycle 21: busy=0, hi=0, lo=0; no done pulse follows; a new MULT 3*4 then yields lo=12 at cycle 33.
REQ-027 MULT 2*3 with start held high through DONE, a=5, b=6 at that edge -> first DONE: lo=6; back-to-back accept; second DONE 33 cycles later: lo=30, hi=0.
